reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 13 +
 rtl/reorder_buffer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared sizing constants for the reorder buffer
package reorder_buffer_pkg;

    // Default geometry: 32-bit results, 8 entries, 3-bit tags, 3-bit thread ids.
    localparam int ROB_XLEN   = 32;
    localparam int ROB_DEPTH  = 8;
    localparam int ROB_TAG_W  = 3;
    localparam int ROB_TID_W  = 3;

    // Architectural register index width (rd field).
    localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order commit reorder buffer with CDB capture and operand lookup
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   stall_i                   freezes allocation and commit; CDB capture continues
//   issue_*                   allocation request written at the tail
//   tag, full, empty          tail tag and occupancy flags
//   cdb_valid/tag/value       result broadcast, captured into busy entries
//   rs1_*/rs2_*               combinational operand lookup with same-cycle CDB bypass
//   reg_*                     registered commit port (reg_en pulses once per commit)
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int XLEN  = ROB_XLEN,
    parameter int DEPTH = ROB_DEPTH,
    parameter int TAG_W = ROB_TAG_W,
    parameter int TID_W = ROB_TID_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  issue_en,
    input  logic [REG_ADDR_W-1:0] issue_dest,
    input  logic [TID_W-1:0]      issue_thread_id,
    input  logic                  issue_valid,
    input  logic [XLEN-1:0]       issue_value,
    output logic [TAG_W-1:0]      tag,
    output logic                  full,
    output logic                  empty,
    input  logic                  cdb_valid,
    input  logic [TAG_W-1:0]      cdb_tag,
    input  logic [XLEN-1:0]       cdb_value,
    input  logic [TAG_W-1:0]      rs1_tag,
    input  logic [TAG_W-1:0]      rs2_tag,
    output logic                  rs1_valid,
    output logic                  rs2_valid,
    output logic [XLEN-1:0]       rs1_value,
    output logic [XLEN-1:0]       rs2_value,
    output logic                  reg_en,
    output logic [REG_ADDR_W-1:0] reg_dest,
    output logic [XLEN-1:0]       reg_value,
    output logic [TID_W-1:0]      reg_thread_id,
    output logic [TAG_W-1:0]      reg_tag
);

    // Control bits are reset; payload fields are don't-care after reset and
    // live in a separate non-reset register array so lookup stays asynchronous.
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      ready;
    logic [REG_ADDR_W-1:0] dest_q  [DEPTH];
    logic [TID_W-1:0]      tid_q   [DEPTH];
    logic [XLEN-1:0]       value_q [DEPTH];

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   count;

    logic do_alloc;
    logic do_commit;
    logic cdb_hit;

    assign full  = (count == (TAG_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign tag   = tail;

    assign do_alloc  = issue_en && !full && !stall_i;
    assign do_commit = !stall_i && busy[head] && ready[head];
    assign cdb_hit   = cdb_valid && busy[cdb_tag];

    // When the buffer is full, tail == head and that entry is busy, so an
    // allocation can never collide with a committing or CDB-written entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy          <= '0;
            ready         <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            reg_en        <= 1'b0;
            reg_dest      <= '0;
            reg_value     <= '0;
            reg_thread_id <= '0;
            reg_tag       <= '0;
        end else begin
            if (cdb_hit) begin
                ready[cdb_tag] <= 1'b1;
            end

            if (do_commit) begin
                busy[head]    <= 1'b0;
                ready[head]   <= 1'b0;
                head          <= head + TAG_W'(1);
                reg_en        <= 1'b1;
                reg_dest      <= dest_q[head];
                reg_value     <= value_q[head];
                reg_thread_id <= tid_q[head];
                reg_tag       <= head;
            end else begin
                reg_en <= 1'b0;
            end

            if (do_alloc) begin
                busy[tail]  <= 1'b1;
                ready[tail] <= issue_valid;
                tail        <= tail + TAG_W'(1);
            end

            case ({do_alloc, do_commit})
                2'b10:   count <= count + (TAG_W+1)'(1);
                2'b01:   count <= count - (TAG_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_alloc) begin
            dest_q[tail]  <= issue_dest;
            tid_q[tail]   <= issue_thread_id;
            value_q[tail] <= issue_value;
        end
        if (cdb_hit) begin
            value_q[cdb_tag] <= cdb_value;
        end
    end

    // Stored ready results win over the bypass; the bypass covers a result
    // that is on the CDB this cycle but not yet written.
    always_comb begin
        rs1_valid = 1'b0;
        rs1_value = '0;
        if (busy[rs1_tag] && ready[rs1_tag]) begin
            rs1_valid = 1'b1;
            rs1_value = value_q[rs1_tag];
        end else if (cdb_valid && (cdb_tag == rs1_tag)) begin
            rs1_valid = 1'b1;
            rs1_value = cdb_value;
        end
    end

    always_comb begin
        rs2_valid = 1'b0;
        rs2_value = '0;
        if (busy[rs2_tag] && ready[rs2_tag]) begin
            rs2_valid = 1'b1;
            rs2_value = value_q[rs2_tag];
        end else if (cdb_valid && (cdb_tag == rs2_tag)) begin
            rs2_valid = 1'b1;
            rs2_value = cdb_value;
        end
    end

endmodule
